// File: rtl/register_file_pkg.sv
// Shared constants and helpers for the register file.
//   clog2         : ceiling log2, usable in constant (parameter) context
//   DEFAULT_WIDTH : default bits per register
//   DEFAULT_DEPTH : default number of registers
package register_file_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DEPTH = 4;

  // Ceiling log2, with a floor of 1 so a 1-bit address always exists.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/register_file_reset_enable_dff.sv
// One storage register with a synchronous active-high reset and a load enable.
// Reset wins over enable.
//   clk    : clock, rising edge
//   reset  : synchronous active-high clear
//   enable : load D on the next rising edge
//   D      : data in
//   Q      : registered data out
module reset_enable_dff
  import register_file_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (enable) q_d = D;
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file with combinational reads.
//   clk, reset       : clock; synchronous active-high reset clears data and flags
//   we/waddr/wdata   : write port
//   raddr_a, rdata_a : read port A (combinational)
//   raddr_b, rdata_b : read port B (combinational)
//   written          : bit i set once register i has taken a write since reset
// Options: ZERO_REG hardwires register 0 to zero; BYPASS forwards a same-cycle
// write to matching read ports.
module register_file
  import register_file_pkg::*;
#(
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int DEPTH    = DEFAULT_DEPTH,
  parameter  int ZERO_REG = 0,
  parameter  int BYPASS   = 1,
  localparam int ADDR_W   = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  output logic [DEPTH-1:0]  written
);

  logic [DEPTH-1:0]            reg_en;
  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0]            written_d, written_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    // A hardwired-zero register 0 never loads, so it also never flags written.
    localparam bit IS_ZERO = (ZERO_REG != 0) && (i == 0);
    assign reg_en[i] = !IS_ZERO && we && (waddr == ADDR_W'(i));

    reset_enable_dff #(.WIDTH(WIDTH)) u_reg (
      .clk    (clk),
      .reset  (reset),
      .enable (reg_en[i]),
      .D      (wdata),
      .Q      (regs[i])
    );
  end

  always_comb begin
    written_d = written_q | reg_en;
  end

  always_ff @(posedge clk) begin
    if (reset) written_q <= '0;
    else       written_q <= written_d;
  end

  assign written = written_q;

  // Zero-register masking is applied last so it also overrides the bypass.
  always_comb begin
    rdata_a = regs[raddr_a];
    if ((BYPASS != 0) && we && (raddr_a == waddr)) rdata_a = wdata;
    if ((ZERO_REG != 0) && (raddr_a == '0))        rdata_a = '0;
  end

  always_comb begin
    rdata_b = regs[raddr_b];
    if ((BYPASS != 0) && we && (raddr_b == waddr)) rdata_b = wdata;
    if ((ZERO_REG != 0) && (raddr_b == '0))        rdata_b = '0;
  end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic clk, reset;
  int   vectors, miscompares;

  // DUT A: defaults (4x4, no zero reg, bypass)
  logic       a_we;
  logic [1:0] a_wa, a_ra, a_rb;
  logic [3:0] a_wd, a_da, a_db, a_wr;
  register_file dut_a (
    .clk(clk), .reset(reset), .we(a_we), .waddr(a_wa), .wdata(a_wd),
    .raddr_a(a_ra), .raddr_b(a_rb), .rdata_a(a_da), .rdata_b(a_db), .written(a_wr)
  );

  // DUT B: 4x4, zero reg, no bypass
  logic       b_we;
  logic [1:0] b_wa, b_ra, b_rb;
  logic [3:0] b_wd, b_da, b_db, b_wr;
  register_file #(.WIDTH(4), .DEPTH(4), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .we(b_we), .waddr(b_wa), .wdata(b_wd),
    .raddr_a(b_ra), .raddr_b(b_rb), .rdata_a(b_da), .rdata_b(b_db), .written(b_wr)
  );

  // Random DUTs: 8x16 in two configurations, sharing one stimulus stream
  logic        r_we;
  logic [3:0]  r_wa, r_ra, r_rb;
  logic [7:0]  r_wd;
  logic [7:0]  r0_da, r0_db, r1_da, r1_db;
  logic [15:0] r0_wr, r1_wr;
  register_file #(.WIDTH(8), .DEPTH(16), .ZERO_REG(0), .BYPASS(1)) dut_r0 (
    .clk(clk), .reset(reset), .we(r_we), .waddr(r_wa), .wdata(r_wd),
    .raddr_a(r_ra), .raddr_b(r_rb), .rdata_a(r0_da), .rdata_b(r0_db), .written(r0_wr)
  );
  register_file #(.WIDTH(8), .DEPTH(16), .ZERO_REG(1), .BYPASS(0)) dut_r1 (
    .clk(clk), .reset(reset), .we(r_we), .waddr(r_wa), .wdata(r_wd),
    .raddr_a(r_ra), .raddr_b(r_rb), .rdata_a(r1_da), .rdata_b(r1_db), .written(r1_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model for the random DUTs: plain arrays, index k = config.
  logic [7:0]  m_mem [2][16];
  logic [15:0] m_wr  [2];
  int          m_zero [2] = '{0, 1};
  int          m_byp  [2] = '{1, 0};

  function automatic logic [7:0] ref_rd(input int k, input logic [3:0] ra);
    if (m_zero[k] != 0 && ra == 4'd0) return 8'h00;
    if (m_byp[k] != 0 && r_we && ra == r_wa) return r_wd;
    return m_mem[k][ra];
  endfunction

  task automatic ref_edge();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int i = 0; i < 16; i++) m_mem[k][i] = 8'h00;
        m_wr[k] = 16'h0;
      end else if (r_we && !(m_zero[k] != 0 && r_wa == 4'd0)) begin
        m_mem[k][r_wa] = r_wd;
        m_wr[k][r_wa]  = 1'b1;
      end
    end
  endtask

  typedef struct {
    logic       rst, we;
    logic [1:0] wa;
    logic [3:0] wd;
    logic [1:0] ra, rb;
    logic [3:0] ea, eb, ewr;
  } vec_t;

  vec_t tbl [10];

  // Drive DUT B for one cycle and check it before the edge.
  task automatic b_step(input logic rst, input logic we, input logic [1:0] wa,
                        input logic [3:0] wd, input logic [1:0] ra, input logic [1:0] rb,
                        input logic [3:0] ea, input logic [3:0] eb, input logic [3:0] ewr,
                        input string name);
    reset = rst; b_we = we; b_wa = wa; b_wd = wd; b_ra = ra; b_rb = rb;
    @(negedge clk);
    check({name, ".rdata_a"}, 32'(b_da), 32'(ea));
    check({name, ".rdata_b"}, 32'(b_db), 32'(eb));
    check({name, ".written"}, 32'(b_wr), 32'(ewr));
    @(posedge clk); #1;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1;
    a_we = 0; a_wa = 0; a_wd = 0; a_ra = 0; a_rb = 0;
    b_we = 0; b_wa = 0; b_wd = 0; b_ra = 0; b_rb = 0;
    r_we = 0; r_wa = 0; r_wd = 0; r_ra = 0; r_rb = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) m_mem[k][i] = 8'h00;
      m_wr[k] = 16'h0;
    end

    //            rst we wa  wd    ra rb  ea    eb    written
    tbl[0] = '{1'b0, 1'b0, 2'd0, 4'h0, 2'd0, 2'd3, 4'h0, 4'h0, 4'b0000};
    tbl[1] = '{1'b0, 1'b1, 2'd2, 4'hA, 2'd2, 2'd2, 4'hA, 4'hA, 4'b0000};
    tbl[2] = '{1'b0, 1'b0, 2'd0, 4'h0, 2'd2, 2'd2, 4'hA, 4'hA, 4'b0100};
    tbl[3] = '{1'b0, 1'b1, 2'd1, 4'h5, 2'd1, 2'd2, 4'h5, 4'hA, 4'b0100};
    tbl[4] = '{1'b0, 1'b1, 2'd1, 4'h6, 2'd1, 2'd1, 4'h6, 4'h6, 4'b0110};
    tbl[5] = '{1'b0, 1'b0, 2'd0, 4'h0, 2'd1, 2'd0, 4'h6, 4'h0, 4'b0110};
    tbl[6] = '{1'b1, 1'b1, 2'd3, 4'h7, 2'd3, 2'd1, 4'h7, 4'h6, 4'b0110};
    tbl[7] = '{1'b0, 1'b0, 2'd0, 4'h0, 2'd3, 2'd1, 4'h0, 4'h0, 4'b0000};
    tbl[8] = '{1'b0, 1'b1, 2'd0, 4'hF, 2'd0, 2'd3, 4'hF, 4'h0, 4'b0000};
    tbl[9] = '{1'b0, 1'b0, 2'd0, 4'h0, 2'd0, 2'd0, 4'hF, 4'hF, 4'b0001};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Table-driven vectors on the default configuration
    for (int i = 0; i < 10; i++) begin
      reset = tbl[i].rst; a_we = tbl[i].we; a_wa = tbl[i].wa; a_wd = tbl[i].wd;
      a_ra = tbl[i].ra; a_rb = tbl[i].rb;
      @(negedge clk);
      check($sformatf("tbl%0d.rdata_a", i), 32'(a_da), 32'(tbl[i].ea));
      check($sformatf("tbl%0d.rdata_b", i), 32'(a_db), 32'(tbl[i].eb));
      check($sformatf("tbl%0d.written", i), 32'(a_wr), 32'(tbl[i].ewr));
      @(posedge clk); #1;
    end
    reset = 1'b0; a_we = 1'b0;

    // Zero register + no bypass: register contents seen after the edge only.
    // DUT B was cleared by the table's reset vector.
    b_step(0, 1, 2'd1, 4'h5, 2'd1, 2'd1, 4'h0, 4'h0, 4'b0000, "nobyp_wr");
    b_step(0, 0, 2'd0, 4'h0, 2'd1, 2'd1, 4'h5, 4'h5, 4'b0010, "nobyp_after");
    b_step(0, 1, 2'd0, 4'hF, 2'd0, 2'd1, 4'h0, 4'h5, 4'b0010, "zero_wr");
    b_step(0, 0, 2'd0, 4'h0, 2'd0, 2'd0, 4'h0, 4'h0, 4'b0010, "zero_after");
    b_step(0, 1, 2'd2, 4'h3, 2'd2, 2'd1, 4'h0, 4'h5, 4'b0010, "b2b_1");
    b_step(0, 1, 2'd2, 4'h9, 2'd2, 2'd2, 4'h3, 4'h3, 4'b0110, "b2b_2");
    b_step(0, 0, 2'd0, 4'h0, 2'd2, 2'd1, 4'h9, 4'h5, 4'b0110, "b2b_after");
    b_step(1, 1, 2'd3, 4'h7, 2'd3, 2'd2, 4'h0, 4'h9, 4'b0110, "rst_wr");
    b_step(0, 0, 2'd0, 4'h0, 2'd3, 2'd2, 4'h0, 4'h0, 4'b0000, "rst_after");
    reset = 1'b0; b_we = 1'b0;

    // Randomised traffic against the array model
    for (int c = 0; c < 1000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      r_we  = ($urandom_range(0, 3) != 0);
      r_wa  = 4'($urandom_range(0, 15));
      r_wd  = 8'($urandom);
      r_ra  = ($urandom_range(0, 3) == 0) ? r_wa : 4'($urandom_range(0, 15));
      r_rb  = ($urandom_range(0, 3) == 0) ? r_ra : 4'($urandom_range(0, 15));
      @(negedge clk);
      check("rnd0.rdata_a", 32'(r0_da), 32'(ref_rd(0, r_ra)));
      check("rnd0.rdata_b", 32'(r0_db), 32'(ref_rd(0, r_rb)));
      check("rnd0.written", 32'(r0_wr), 32'(m_wr[0]));
      check("rnd1.rdata_a", 32'(r1_da), 32'(ref_rd(1, r_ra)));
      check("rnd1.rdata_b", 32'(r1_db), 32'(ref_rd(1, r_rb)));
      check("rnd1.written", 32'(r1_wr), 32'(m_wr[1]));
      @(posedge clk);
      ref_edge();
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
